// File: rtl/spike_mon_pkg.sv
// spike_mon_pkg: shared state encoding and default widths for the spike rate monitor.
package spike_mon_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable saturating up-counter with sticky clip flag.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count_nxt,
  output logic         sat_nxt
);
  logic [W-1:0] count;
  logic         sat;
  logic         at_max;
  // Outputs show the value including this cycle's increment so a window's last spike is counted.
  always_comb begin
    at_max    = &count;
    count_nxt = (inc && !at_max) ? count + 1'b1 : count;
    sat_nxt   = sat | (inc & at_max);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      sat   <= sat_nxt;
    end
  end
endmodule

// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor: counts neuron spikes over a window of enabled cycles and
// hands the count to a consumer with valid/ready, saturation and overrun flags.
module spike_rate_monitor
  import spike_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             saturated,
  output logic             overrun,
  output logic             busy
);
  state_t           state, state_nxt;
  logic [WIN_W:0]   remaining, len_q, load_len;
  logic             cont_q, run, go, halt, win_end;
  logic [CNT_W-1:0] count_nxt;
  logic             sat_nxt;
  always_comb begin
    run       = state == RUN;
    go        = !run && start && !stop;
    halt      = run && stop;
    win_end   = run && !stop && enable && remaining == (WIN_W+1)'(1);
    load_len  = window_len == '0 ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len};
    state_nxt = go ? RUN : (halt || (win_end && !cont_q)) ? IDLE : state;
  end
  assign busy = run;
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (go | win_end | halt),
    .inc       (run & enable & spike_in),
    .count_nxt (count_nxt),
    .sat_nxt   (sat_nxt)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining  <= '0;
      len_q      <= '0;
      cont_q     <= 1'b0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      saturated  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (go) begin
        remaining <= load_len;
        len_q     <= load_len;
        cont_q    <= continuous;
        overrun   <= 1'b0;
      end else if (halt) remaining <= '0;
      else if (win_end)  remaining <= cont_q ? len_q : '0;
      else if (run && enable) remaining <= remaining - 1'b1;
      // A result landing on the consuming edge replaces it without counting as an overrun.
      if (win_end) begin
        rate_out   <= count_nxt;
        saturated  <= sat_nxt;
        rate_valid <= 1'b1;
        if (rate_valid && !rate_ready) overrun <= 1'b1;
      end else if (rate_valid && rate_ready) rate_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spike_rate_monitor.sv
// tb_spike_rate_monitor: directed and random checks against a window-level reference model.
module tb_spike_rate_monitor;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       enable = 1'b0, spike_in = 1'b0, start = 1'b0, stop = 1'b0;
  logic       continuous = 1'b0, rate_ready = 1'b0;
  logic [7:0] window_len = 8'd0;
  logic [7:0] rate_out;
  logic       rate_valid, saturated, overrun, busy;
  int vectors = 0, errors = 0;
  bit m_run, m_cont, m_valid, m_sat, m_ovr;
  int m_len, m_seen, m_spk, m_out;
  logic [11:0] obs, exp_v;

  spike_rate_monitor dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .spike_in(spike_in),
    .window_len(window_len), .start(start), .stop(stop), .continuous(continuous),
    .rate_out(rate_out), .rate_valid(rate_valid), .rate_ready(rate_ready),
    .saturated(saturated), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_sat = 0; m_ovr = 0; m_out = 0; m_seen = 0; m_spk = 0;
  endtask

  // Window-level model: count enabled cycles up to the length, publish spike total.
  task automatic tick(input logic en, input logic sp, input logic st, input logic sto, input logic rdy);
    bit new_res;
    enable = en; spike_in = sp; start = st; stop = sto; rate_ready = rdy;
    @(posedge clk);
    new_res = 0;
    if (!m_run) begin
      if (st && !sto) begin
        m_run = 1; m_len = (window_len == 0) ? 256 : int'(window_len);
        m_cont = continuous; m_seen = 0; m_spk = 0; m_ovr = 0;
      end
    end else if (sto) m_run = 0;
    else if (en) begin
      m_seen++; m_spk += int'(sp);
      if (m_seen == m_len) begin
        new_res = 1;
        if (m_valid && !rdy) m_ovr = 1;
        m_out = (m_spk > 255) ? 255 : m_spk;
        m_sat = m_spk > 255; m_valid = 1; m_seen = 0; m_spk = 0;
        if (!m_cont) m_run = 0;
      end
    end
    if (!new_res && m_valid && rdy) m_valid = 0;
    #1;
    obs   = {busy, rate_valid, saturated, overrun, rate_out};
    exp_v = {m_run, m_valid, m_sat, m_ovr, 8'(m_out)};
  endtask

  task automatic test_reset();
    reset_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #1; vectors++;
    if ({busy, rate_valid, saturated, overrun, rate_out} !== 12'h0) begin
      errors++; $display("FAIL reset_hold got=%h want=000", {busy, rate_valid, saturated, overrun, rate_out});
    end
    reset_n = 1;
    tick(0, 0, 1, 0, 0); vectors++;
    if (busy !== 1'b1 || obs !== exp_v) begin
      errors++; $display("FAIL first_start got=%h want=%h", obs, exp_v);
    end
    tick(0, 0, 0, 1, 0); vectors++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_stop got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_single_window();
    window_len = 8'd10; continuous = 0;
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, (i == 1 || i == 4 || i == 7 || i == 9), 0, 0, 0); vectors++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_win cyc%0d got=%h want=%h", i, obs, exp_v); end
    end
    vectors++;
    if (rate_out !== 8'd4 || rate_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_result got=%0d/%b/%b want=4/1/0", rate_out, rate_valid, busy);
    end
    tick(0, 0, 0, 0, 1); vectors++;
    if (rate_valid !== 1'b0 || obs !== exp_v) begin errors++; $display("FAIL single_consume got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_gated();
    window_len = 8'd4; continuous = 0;
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(logic'(i % 2), 1, 0, 0, 0); vectors++;
      if (obs !== exp_v) begin errors++; $display("FAIL gated cyc%0d got=%h want=%h", i, obs, exp_v); end
      if (i == 6) begin
        vectors++;
        if (rate_valid !== 1'b0) begin errors++; $display("FAIL gated_early got=%b want=0", rate_valid); end
      end
    end
    vectors++;
    if (rate_out !== 8'd4 || rate_valid !== 1'b1) begin
      errors++; $display("FAIL gated_result got=%0d/%b want=4/1", rate_out, rate_valid);
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_saturation();
    window_len = 8'd0; continuous = 0;
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      tick(1, 1, 0, 0, 0); vectors++;
      if (obs !== exp_v) begin errors++; $display("FAIL sat cyc%0d got=%h want=%h", i, obs, exp_v); end
    end
    vectors++;
    if (rate_out !== 8'd255 || saturated !== 1'b1) begin
      errors++; $display("FAIL sat_result got=%0d/%b want=255/1", rate_out, saturated);
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_overrun();
    window_len = 8'd3; continuous = 1;
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1, logic'(i > 2), 0, 0, 0); vectors++;
      if (obs !== exp_v) begin errors++; $display("FAIL ovr cyc%0d got=%h want=%h", i, obs, exp_v); end
    end
    vectors++;
    if (overrun !== 1'b1 || rate_out !== 8'd3) begin
      errors++; $display("FAIL ovr_set got=%b/%0d want=1/3", overrun, rate_out);
    end
    tick(0, 0, 0, 1, 1);
    tick(1, 0, 1, 0, 0); vectors++;
    if (overrun !== 1'b0 || obs !== exp_v) begin errors++; $display("FAIL ovr_clear got=%h want=%h", obs, exp_v); end
    for (int i = 0; i < 6; i++) begin
      tick(1, logic'(i == 5), 0, 0, logic'(i == 5)); vectors++;
      if (obs !== exp_v) begin errors++; $display("FAIL ovr_same cyc%0d got=%h want=%h", i, obs, exp_v); end
    end
    vectors++;
    if (rate_valid !== 1'b1 || overrun !== 1'b0 || rate_out !== 8'd1) begin
      errors++; $display("FAIL same_edge got=%b/%b/%0d want=1/0/1", rate_valid, overrun, rate_out);
    end
    tick(0, 0, 0, 1, 1);
  endtask

  task automatic test_abort();
    window_len = 8'd5; continuous = 0;
    tick(0, 0, 1, 1, 0); vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_over_start got=%b want=0", busy); end
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 1, 0); vectors++;
    if (busy !== 1'b0 || rate_valid !== 1'b0 || obs !== exp_v) begin
      errors++; $display("FAIL stop_at_end got=%h want=%h", obs, exp_v);
    end
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    #1 reset_n = 0; model_reset();
    #1; vectors++;
    if ({busy, rate_valid, saturated, overrun, rate_out} !== 12'h0) begin
      errors++; $display("FAIL reset_mid_run got=%h want=000", {busy, rate_valid, saturated, overrun, rate_out});
    end
    reset_n = 1;
    tick(1, 1, 0, 0, 0); vectors++;
    if (obs !== exp_v) begin errors++; $display("FAIL no_resume got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      window_len = ($urandom_range(0, 30) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      continuous = logic'($urandom_range(0, 1));
      tick(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 60) == 0),
           logic'($urandom_range(0, 2) == 0));
      vectors++;
      if (obs !== exp_v) begin errors++; $display("FAIL random cyc%0d got=%h want=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_window();
    test_gated();
    test_saturation();
    test_overrun();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
